// File: rtl/clock_pkg.sv
// Shared types and constants for the stopwatch time base and its control FSM.
package clock_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] DIG_MAX_DEC = 4'd9;
    localparam logic [BCD_W-1:0] DIG_MAX_HEX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time-base cascade: counts 0..MAX on inc and carries out on wrap.
module bcd_digit_cnt
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIG_MAX_DEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    // Out-of-range values fold back to zero on the next carry-in.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q >= MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign carry = inc && (q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: key edge detection, IDLE/RUN/PAUSE FSM, tick prescaler and
// a BCD mm:ss.cc time base feeding the display multiplexer.
module stopwatch_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_rst_en,
    input  logic       key_ps_en,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       paused,
    output logic       ovf
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    state_t state, state_nxt;

    logic key_rst_q, key_ps_q;
    logic rst_arm, ps_arm;
    logic rst_evt, ps_evt;
    logic [15:0] presc;
    logic tick;

    logic [BCD_W-1:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
    logic [5:0] carry;

    // The arm flags ignore a key held through reset release until it is seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_rst_q <= 1'b0;
            key_ps_q  <= 1'b0;
            rst_arm   <= 1'b0;
            ps_arm    <= 1'b0;
            rst_evt   <= 1'b0;
            ps_evt    <= 1'b0;
        end else begin
            key_rst_q <= key_rst_en;
            key_ps_q  <= key_ps_en;
            rst_arm   <= rst_arm | ~key_rst_en;
            ps_arm    <= ps_arm | ~key_ps_en;
            rst_evt   <= key_rst_en & ~key_rst_q & rst_arm;
            ps_evt    <= key_ps_en & ~key_ps_q & ps_arm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A reset-key event wins over a simultaneous pause/start event.
    always_comb begin
        state_nxt = state;
        if (rst_evt) begin
            state_nxt = IDLE;
        end else if (ps_evt) begin
            unique case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst || rst_evt) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 16'd1;
        end
    end

    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_cs_u (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(tick),     .q(cs_u),  .carry(carry[0])
    );
    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_cs_t (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(carry[0]), .q(cs_t),  .carry(carry[1])
    );
    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_sec_u (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(carry[1]), .q(sec_u), .carry(carry[2])
    );
    bcd_digit_cnt #(.MAX(DIG_MAX_HEX)) u_sec_t (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(carry[2]), .q(sec_t), .carry(carry[3])
    );
    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_min_u (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(carry[3]), .q(min_u), .carry(carry[4])
    );
    bcd_digit_cnt #(.MAX(DIG_MAX_HEX)) u_min_t (
        .clk(clk), .rst(rst), .clr(rst_evt), .inc(carry[4]), .q(min_t), .carry(carry[5])
    );

    // The carry out of the minutes-tens digit is the 59:59.99 -> 00:00.00 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= carry[5] & ~rst_evt;
        end
    end

    assign cs_bcd  = {cs_t, cs_u};
    assign sec_bcd = {sec_t, sec_u};
    assign min_bcd = {min_t, min_u};
    assign running = (state == RUN);
    assign paused  = (state == PAUSE);

endmodule
